// File: rtl/axis_frame_scheduler.sv
// Frame-level gate on an AXI4-Stream video bus: forwards or discards whole frames
// at SOF based on run enable and decimation, and checks line/frame geometry.
module axis_frame_scheduler #(
  parameter int unsigned C_WIDTH       = 8,
  parameter int unsigned PIXEL_PER_CLK = 1,
  parameter int unsigned TUSER_WIDTH   = 2
) (
  input  logic                               i_axis_clk,
  input  logic                               i_axis_resetn,
  input  logic                               i_enable,
  input  logic [3:0]                         i_decim,
  input  logic [11:0]                        i_hres,
  input  logic [11:0]                        i_vres,
  input  logic                               i_clear_stats,
  input  logic [PIXEL_PER_CLK*3*C_WIDTH-1:0] s_axis_tdata,
  input  logic                               s_axis_tvalid,
  input  logic                               s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]             s_axis_tuser,
  output logic                               s_axis_tready,
  output logic [PIXEL_PER_CLK*3*C_WIDTH-1:0] m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]             m_axis_tuser,
  input  logic                               m_axis_tready,
  output logic [15:0]                        o_frames_passed,
  output logic [15:0]                        o_frames_dropped,
  output logic                               o_err_line,
  output logic                               o_err_frame,
  output logic                               o_busy
);

  localparam int unsigned POS_W = 12;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {WAIT_SOF, PASS, DROP} state_t;

  state_t            state;
  state_t            frame_state;
  state_t            next_state;
  logic [3:0]        dec_cnt;
  logic [POS_W-1:0]  h_cnt;
  logic [POS_W-1:0]  v_cnt;
  logic [POS_W-1:0]  cur_h;
  logic [POS_W-1:0]  cur_v;
  logic              sof_in;
  logic              eof_in;
  logic              accept;
  logic              fwd;
  logic              beat;
  logic              in_frame;
  logic              take;
  logic              frame_end;
  logic              pass_inc;
  logic [1:0]        drop_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(inc);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign sof_in   = s_axis_tuser[0];
  assign eof_in   = s_axis_tuser[1];
  assign accept   = i_enable & (dec_cnt == 4'd0);
  assign in_frame = (state != WAIT_SOF);

  // An SOF beat is routed by the fresh decision; everything else by the frame state.
  always_comb begin
    fwd = (state == PASS);
    if (s_axis_tvalid && sof_in) fwd = accept;
  end

  assign s_axis_tready = fwd ? m_axis_tready : 1'b1;
  assign m_axis_tvalid = s_axis_tvalid & fwd;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tuser  = s_axis_tuser;

  assign beat = s_axis_tvalid & s_axis_tready;
  assign take = beat & (sof_in | in_frame);

  // The SOF beat itself sits at h = 0, v = 0 of the frame it opens.
  assign cur_h       = sof_in ? '0 : h_cnt;
  assign cur_v       = sof_in ? '0 : v_cnt;
  assign frame_end   = s_axis_tlast & (cur_v == i_vres - 12'd1);
  assign frame_state = sof_in ? (accept ? PASS : DROP) : state;
  assign next_state  = frame_end ? WAIT_SOF : frame_state;

  assign pass_inc = take & frame_end & (frame_state == PASS);
  assign drop_inc = 2'({1'b0, take & sof_in & in_frame})
                  + 2'({1'b0, take & frame_end & (frame_state == DROP)});

  always_ff @(posedge i_axis_clk or negedge i_axis_resetn) begin
    if (!i_axis_resetn) begin
      state            <= WAIT_SOF;
      dec_cnt          <= '0;
      h_cnt            <= '0;
      v_cnt            <= '0;
      o_busy           <= 1'b0;
      o_frames_passed  <= '0;
      o_frames_dropped <= '0;
      o_err_line       <= 1'b0;
      o_err_frame      <= 1'b0;
    end else begin
      if (take) begin
        state  <= next_state;
        o_busy <= (next_state == PASS);
        if (sof_in) dec_cnt <= (dec_cnt == i_decim) ? 4'd0 : dec_cnt + 4'd1;
        if (s_axis_tlast) begin
          h_cnt <= '0;
          v_cnt <= cur_v + 12'd1;
        end else begin
          h_cnt <= cur_h + 12'd1;
          v_cnt <= cur_v;
        end
      end

      // Clear has priority over any same-cycle update of the statistics.
      if (i_clear_stats) begin
        o_frames_passed  <= '0;
        o_frames_dropped <= '0;
        o_err_line       <= 1'b0;
        o_err_frame      <= 1'b0;
      end else begin
        o_frames_passed  <= sat_add(o_frames_passed, {1'b0, pass_inc});
        o_frames_dropped <= sat_add(o_frames_dropped, drop_inc);
        if (take && s_axis_tlast && (cur_h != i_hres - 12'd1)) o_err_line <= 1'b1;
        if (take && ((eof_in != frame_end) || (sof_in && in_frame))) o_err_frame <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_scheduler.sv
// Randomized bench for axis_frame_scheduler: a frame-level reference model is
// compared against the DUT every cycle, plus literal checkpoints after each scenario.
module tb_axis_frame_scheduler;

  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_enable;
  logic [3:0]    i_decim;
  logic [11:0]   i_hres;
  logic [11:0]   i_vres;
  logic          i_clear_stats;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic [1:0]    s_axis_tuser;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic [1:0]    m_axis_tuser;
  logic          m_axis_tready;
  logic [15:0]   o_frames_passed;
  logic [15:0]   o_frames_dropped;
  logic          o_err_line;
  logic          o_err_frame;
  logic          o_busy;

  always #5 clk = ~clk;

  axis_frame_scheduler #(.C_WIDTH(8), .PIXEL_PER_CLK(1), .TUSER_WIDTH(2)) dut (
    .i_axis_clk(clk), .i_axis_resetn(rst_n),
    .i_enable(i_enable), .i_decim(i_decim), .i_hres(i_hres), .i_vres(i_vres),
    .i_clear_stats(i_clear_stats),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .o_frames_passed(o_frames_passed), .o_frames_dropped(o_frames_dropped),
    .o_err_line(o_err_line), .o_err_frame(o_err_frame), .o_busy(o_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int out_beats = 0;
  bit rnd_ready = 1'b0;
  bit gaps = 1'b0;

  // Reference model: frame-level bookkeeping
  int m_phase, m_col, m_row, m_passed, m_dropped;
  bit m_in_frame, m_fwd, m_err_line, m_err_frame;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit sof, acc, fwd_now, exp_rdy, exp_val, last_row, set_el, set_ef;
    int inc_p, inc_d;
    if (!rst_n) begin
      m_phase = 0; m_col = 0; m_row = 0; m_passed = 0; m_dropped = 0;
      m_in_frame = 0; m_fwd = 0; m_err_line = 0; m_err_frame = 0;
    end else begin
      sof     = s_axis_tvalid && s_axis_tuser[0];
      acc     = i_enable && (m_phase == 0);
      fwd_now = sof ? acc : (m_in_frame && m_fwd);
      exp_rdy = fwd_now ? m_axis_tready : 1'b1;
      exp_val = s_axis_tvalid && fwd_now;

      chk("s_tready", s_axis_tready, exp_rdy);
      chk("m_tvalid", m_axis_tvalid, exp_val);
      chk("busy", o_busy, m_in_frame && m_fwd);
      chk("frames_passed", o_frames_passed, m_passed);
      chk("frames_dropped", o_frames_dropped, m_dropped);
      chk("err_line", o_err_line, m_err_line);
      chk("err_frame", o_err_frame, m_err_frame);
      if (exp_val) begin
        chk("m_tdata", m_axis_tdata, s_axis_tdata);
        chk("m_tlast", m_axis_tlast, s_axis_tlast);
        chk("m_tuser", m_axis_tuser, s_axis_tuser);
      end
      if (m_axis_tvalid && m_axis_tready) out_beats++;

      inc_p = 0; inc_d = 0; set_el = 0; set_ef = 0;
      if (s_axis_tvalid && exp_rdy) begin
        if (sof) begin
          if (m_in_frame) begin set_ef = 1; inc_d++; end
          m_phase    = (m_phase == int'(i_decim)) ? 0 : (m_phase + 1) % 16;
          m_in_frame = 1; m_fwd = acc; m_col = 0; m_row = 0;
        end
        if (m_in_frame) begin
          last_row = (m_row == int'(i_vres) - 1);
          if (s_axis_tuser[1] != (s_axis_tlast && last_row)) set_ef = 1;
          if (s_axis_tlast) begin
            if (m_col != int'(i_hres) - 1) set_el = 1;
            if (last_row) begin
              m_in_frame = 0;
              if (m_fwd) inc_p++; else inc_d++;
            end else begin
              m_row++; m_col = 0;
            end
          end else m_col++;
        end
      end
      if (i_clear_stats) begin
        m_passed = 0; m_dropped = 0; m_err_line = 0; m_err_frame = 0;
      end else begin
        m_passed  = (m_passed + inc_p > 65535) ? 65535 : m_passed + inc_p;
        m_dropped = (m_dropped + inc_d > 65535) ? 65535 : m_dropped + inc_d;
        if (set_el) m_err_line = 1;
        if (set_ef) m_err_frame = 1;
      end
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_ready ? 1'($urandom) : 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input bit sof, input bit eof, input bit last, input bit clr);
    bit done;
    s_axis_tvalid = 1'b0;
    if (gaps) idle($urandom_range(0, 2));
    s_axis_tdata  = DW'($urandom);
    s_axis_tuser  = {eof, sof};
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    i_clear_stats = clr;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk); done = s_axis_tready;
      @(posedge clk); #1;
    end
    if (!done) chk("beat_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
    i_clear_stats = 1'b0;
  endtask

  // All beats of an h x v frame except the SOF beat; optional clear on the final beat.
  task automatic send_rest(input int h, input int v, input bit clr_last);
    for (int r = 0; r < v; r++)
      for (int c = 0; c < h; c++)
        if (r != 0 || c != 0) begin
          bit fin;
          fin = (r == v - 1) && (c == h - 1);
          send_beat(1'b0, fin, c == h - 1, clr_last && fin);
        end
  endtask

  task automatic send_frame(input int h, input int v);
    send_beat(1'b1, 1'b0, h == 1, 1'b0);
    send_rest(h, v, 1'b0);
  endtask

  task automatic pulse_clear();
    i_clear_stats = 1'b1; idle(1); i_clear_stats = 1'b0;
  endtask

  initial begin
    int out0;
    rst_n = 1'b1; i_enable = 1'b1; i_decim = 4'd0; i_hres = 12'd4; i_vres = 12'd2;
    i_clear_stats = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tuser = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    chk("reset_passed", o_frames_passed, 0);
    chk("reset_sready", s_axis_tready, 1);
    chk("reset_mvalid", m_axis_tvalid, 0);
    chk("reset_busy", o_busy, 0);

    // Three clean frames, all forwarded
    out0 = out_beats;
    repeat (3) send_frame(4, 2);
    idle(2);
    chk("clean_beats", out_beats - out0, 24);
    chk("clean_passed", o_frames_passed, 3);
    chk("clean_err_line", o_err_line, 0);
    chk("clean_err_frame", o_err_frame, 0);

    // Decimation 1 of 3: frames 0 and 3 forwarded
    pulse_clear();
    i_decim = 4'd2; out0 = out_beats;
    repeat (6) send_frame(4, 2);
    idle(2);
    chk("decim_passed", o_frames_passed, 2);
    chk("decim_dropped", o_frames_dropped, 4);
    chk("decim_beats", out_beats - out0, 16);

    // Random downstream backpressure and upstream gaps
    i_decim = 4'd0; pulse_clear();
    rnd_ready = 1'b1; gaps = 1'b1; out0 = out_beats;
    repeat (4) send_frame(4, 2);
    rnd_ready = 1'b0; gaps = 1'b0;
    idle(3);
    chk("bp_beats", out_beats - out0, 32);
    chk("bp_passed", o_frames_passed, 4);

    // Short second line
    pulse_clear();
    send_beat(1, 0, 0, 0); send_beat(0, 0, 0, 0); send_beat(0, 0, 0, 0); send_beat(0, 0, 1, 0);
    send_beat(0, 0, 0, 0); send_beat(0, 0, 0, 0); send_beat(0, 1, 1, 0);
    idle(2);
    chk("short_err_line", o_err_line, 1);
    chk("short_passed", o_frames_passed, 1);
    chk("short_busy", o_busy, 0);

    // SOF injected at v=1, h=1
    pulse_clear(); out0 = out_beats;
    send_beat(1, 0, 0, 0); send_beat(0, 0, 0, 0); send_beat(0, 0, 0, 0); send_beat(0, 0, 1, 0);
    send_beat(0, 0, 0, 0);
    send_frame(4, 2);
    idle(2);
    chk("inject_err_frame", o_err_frame, 1);
    chk("inject_dropped", o_frames_dropped, 1);
    chk("inject_passed", o_frames_passed, 1);
    chk("inject_beats", out_beats - out0, 13);

    // Enable dropped mid-frame
    pulse_clear();
    send_beat(1, 0, 0, 0);
    i_enable = 1'b0;
    send_rest(4, 2, 1'b0);
    send_frame(4, 2);
    idle(2);
    chk("en_passed", o_frames_passed, 1);
    chk("en_dropped", o_frames_dropped, 1);

    // Clear coincident with a frame end
    i_enable = 1'b1;
    send_beat(1, 0, 0, 0);
    send_rest(4, 2, 1'b1);
    idle(2);
    chk("clr_passed", o_frames_passed, 0);
    chk("clr_dropped", o_frames_dropped, 0);
    chk("clr_err_frame", o_err_frame, 0);

    // Reset mid-frame; remainder is discarded
    send_beat(1, 0, 0, 0); send_beat(0, 0, 0, 0);
    rst_n = 1'b0; idle(2); rst_n = 1'b1;
    chk("rst_busy", o_busy, 0);
    out0 = out_beats;
    send_beat(0, 0, 0, 0); send_beat(0, 0, 1, 0);
    send_beat(0, 0, 0, 0); send_beat(0, 0, 0, 0); send_beat(0, 0, 0, 0); send_beat(0, 1, 1, 0);
    send_frame(4, 2);
    idle(2);
    chk("rst_beats", out_beats - out0, 8);
    chk("rst_passed", o_frames_passed, 1);
    chk("rst_err_frame", o_err_frame, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
